// File: rtl/acc_mem_bridge.sv
// Memory-mapped bridge between the core data bus and the matrix accelerator:
// operand buffers A/B, result buffer C, control/status and a run-cycle counter.
module acc_mem_bridge #(
    parameter int DATA_W    = 8,
    parameter int MAT_DEPTH = 1024,
    parameter int BUS_W     = 32,
    parameter int ADDR_W    = 32,
    parameter int CNT_W     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req,
    input  logic                          we,
    input  logic [ADDR_W-1:0]             addr,
    input  logic [BUS_W-1:0]              data_in,
    output logic [BUS_W-1:0]              data_out,
    output logic                          rvalid,
    output logic                          acc_start,
    input  logic                          acc_done,
    output logic [MAT_DEPTH*DATA_W-1:0]   acc_in_A,
    output logic [MAT_DEPTH*DATA_W-1:0]   acc_in_B,
    input  logic [MAT_DEPTH*DATA_W-1:0]   acc_out_C,
    output logic                          irq
);
    localparam int DW = $clog2(MAT_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r, state_next_s;
    logic [DATA_W-1:0]   a_mem_r [MAT_DEPTH];
    logic [DATA_W-1:0]   b_mem_r [MAT_DEPTH];
    logic [DATA_W-1:0]   c_mem_r [MAT_DEPTH];
    logic [CNT_W-1:0]    cyc_r;
    logic                err_r;
    logic                acc_start_r, irq_r, rvalid_r;
    logic                acc_start_next_s, irq_next_s;
    logic [BUS_W-1:0]    data_out_r, rd_data_s;
    logic [1:0]          region_s;
    logic [DW-1:0]       offset_s;
    logic                wr_s, rd_s, ctrl_wr_s, start_req_s, clear_req_s;
    logic                start_ok_s, capture_s, err_set_s, ab_wr_ok_s;
    logic                unused_bits_s;

    // Upper address bits alias by design and data_in bits above DATA_W are don't-care.
    assign unused_bits_s = ^{addr, data_in};

    assign region_s    = addr[DW+1:DW];
    assign offset_s    = addr[DW-1:0];
    assign wr_s        = req & we;
    assign rd_s        = req & ~we;
    assign ctrl_wr_s   = wr_s && (region_s == 2'd0) && (offset_s == DW'(0));
    assign start_req_s = ctrl_wr_s & data_in[0];
    assign clear_req_s = ctrl_wr_s & data_in[1];
    assign start_ok_s  = start_req_s && (state_r != ST_RUN);
    assign capture_s   = (state_r == ST_RUN) && acc_done;
    assign ab_wr_ok_s  = wr_s && (state_r != ST_RUN);
    assign err_set_s   = (start_req_s && (state_r == ST_RUN))
                       || (wr_s && (state_r == ST_RUN) && ((region_s == 2'd1) || (region_s == 2'd2)))
                       || (wr_s && (region_s == 2'd3));

    // Controller state register and registered controller outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            acc_start_r <= 1'b0;
            irq_r       <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            acc_start_r <= acc_start_next_s;
            irq_r       <= irq_next_s;
        end
    end

    // Next-state logic; CLEAR is applied before START, so CTRL=3 from DONE restarts.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) state_next_s = ST_RUN;
                else            state_next_s = ST_IDLE;
            end
            ST_RUN: begin
                if (acc_done) state_next_s = ST_DONE;
                else          state_next_s = ST_RUN;
            end
            ST_DONE: begin
                if (start_ok_s)       state_next_s = ST_RUN;
                else if (clear_req_s) state_next_s = ST_IDLE;
                else                  state_next_s = ST_DONE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Controller output decode, registered one edge later alongside the state.
    always_comb begin
        acc_start_next_s = start_ok_s;
        irq_next_s       = (state_next_s == ST_DONE);
    end

    // Sticky error flag: CLEAR wipes it, then this cycle's violations set it.
    always_ff @(posedge clk) begin
        if (rst) err_r <= 1'b0;
        else     err_r <= (err_r & ~clear_req_s) | err_set_s;
    end

    // Saturating run-cycle counter, restarted on every accepted START.
    always_ff @(posedge clk) begin
        if (rst)                                      cyc_r <= '0;
        else if (start_ok_s)                          cyc_r <= '0;
        else if ((state_r == ST_RUN) && (cyc_r != CNT_MAX)) cyc_r <= cyc_r + CNT_W'(1);
        else                                          cyc_r <= cyc_r;
    end

    // Operand buffers (locked during a run) and result capture on acc_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAT_DEPTH; i++) begin
                a_mem_r[i] <= '0;
                b_mem_r[i] <= '0;
                c_mem_r[i] <= '0;
            end
        end else begin
            if (ab_wr_ok_s && (region_s == 2'd1)) a_mem_r[offset_s] <= data_in[DATA_W-1:0];
            if (ab_wr_ok_s && (region_s == 2'd2)) b_mem_r[offset_s] <= data_in[DATA_W-1:0];
            if (capture_s) begin
                for (int i = 0; i < MAT_DEPTH; i++) c_mem_r[i] <= acc_out_C[i*DATA_W +: DATA_W];
            end
        end
    end

    // Read data mux over pre-edge state.
    always_comb begin
        rd_data_s = '0;
        case (region_s)
            2'd0: begin
                if (offset_s == DW'(1))      rd_data_s = BUS_W'({err_r, (state_r == ST_DONE), (state_r == ST_RUN)});
                else if (offset_s == DW'(2)) rd_data_s = BUS_W'(cyc_r);
                else                         rd_data_s = '0;
            end
            2'd1:    rd_data_s = BUS_W'(a_mem_r[offset_s]);
            2'd2:    rd_data_s = BUS_W'(b_mem_r[offset_s]);
            2'd3:    rd_data_s = BUS_W'(c_mem_r[offset_s]);
            default: rd_data_s = '0;
        endcase
    end

    // Single-stage read pipeline; data_out holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_r <= '0;
            rvalid_r   <= 1'b0;
        end else begin
            rvalid_r <= rd_s;
            if (rd_s) data_out_r <= rd_data_s;
            else      data_out_r <= data_out_r;
        end
    end

    for (genvar g = 0; g < MAT_DEPTH; g++) begin : g_flat
        assign acc_in_A[g*DATA_W +: DATA_W] = a_mem_r[g];
        assign acc_in_B[g*DATA_W +: DATA_W] = b_mem_r[g];
    end

    assign data_out  = data_out_r;
    assign rvalid    = rvalid_r;
    assign acc_start = acc_start_r;
    assign irq       = irq_r;
endmodule

// File: tb/tb_acc_mem_bridge.sv
// Self-checking bench for acc_mem_bridge: directed scenarios plus randomized
// traffic against a transaction-level reference model; a second small instance.
module tb_acc_mem_bridge;
    localparam int DEP = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, req, we, acc_done;
    logic [31:0]       addr, data_in, data_out;
    logic              rvalid, acc_start, irq;
    logic [DEP*8-1:0]  acc_in_A, acc_in_B, acc_out_C;

    logic              s_rst, s_req, s_we, s_acc_done;
    logic [31:0]       s_addr, s_data_in, s_data_out;
    logic              s_rvalid, s_acc_start, s_irq;
    logic [255:0]      s_acc_in_A, s_acc_in_B, s_acc_out_C;

    acc_mem_bridge dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .data_in(data_in),
        .data_out(data_out), .rvalid(rvalid), .acc_start(acc_start), .acc_done(acc_done),
        .acc_in_A(acc_in_A), .acc_in_B(acc_in_B), .acc_out_C(acc_out_C), .irq(irq)
    );

    acc_mem_bridge #(.DATA_W(16), .MAT_DEPTH(16), .BUS_W(32), .ADDR_W(32), .CNT_W(4)) dut_small (
        .clk(clk), .rst(s_rst), .req(s_req), .we(s_we), .addr(s_addr), .data_in(s_data_in),
        .data_out(s_data_out), .rvalid(s_rvalid), .acc_start(s_acc_start), .acc_done(s_acc_done),
        .acc_in_A(s_acc_in_A), .acc_in_B(s_acc_in_B), .acc_out_C(s_acc_out_C), .irq(s_irq)
    );

    // Reference model: buffers as arrays, controller as two flags.
    logic [7:0]  m_a [DEP];
    logic [7:0]  m_b [DEP];
    logic [7:0]  m_c [DEP];
    bit          m_running, m_finished, m_err;
    longint      m_cycles;
    logic [31:0] exp_rdata;
    bit          exp_rvalid, exp_start, exp_irq;
    int          n_cmp, n_fail;

    function automatic logic [31:0] mk(int rg, int off);
        logic [31:0] up = $urandom();
        logic [1:0]  r2 = rg[1:0];
        logic [9:0]  o10 = off[9:0];
        return {up[19:0], r2, o10};
    endfunction

    function automatic logic [31:0] model_read(logic [31:0] a);
        int rg = int'(a[11:10]);
        int off = int'(a[9:0]);
        case (rg)
            0: begin
                if (off == 1)      return {29'd0, m_err, m_finished, m_running};
                else if (off == 2) return m_cycles[31:0];
                else               return 32'd0;
            end
            1:       return {24'd0, m_a[off]};
            2:       return {24'd0, m_b[off]};
            default: return {24'd0, m_c[off]};
        endcase
    endfunction

    // Apply this cycle's inputs to the model, then advance one clock.
    task automatic tick();
        int rg = int'(addr[11:10]);
        int off = int'(addr[9:0]);
        bit run0 = m_running;
        exp_start = 1'b0;
        if (req && !we) exp_rdata = model_read(addr);
        exp_rvalid = req && !we;
        if (rst) begin
            for (int i = 0; i < DEP; i++) begin m_a[i] = 8'd0; m_b[i] = 8'd0; m_c[i] = 8'd0; end
            m_running = 1'b0; m_finished = 1'b0; m_err = 1'b0; m_cycles = 0;
            exp_rvalid = 1'b0; exp_rdata = 32'd0;
        end else begin
            if (run0 && m_cycles != 64'hFFFF_FFFF) m_cycles = m_cycles + 1;
            if (req && we) begin
                if (rg == 0 && off == 0) begin
                    if (data_in[1]) begin m_err = 1'b0; m_finished = 1'b0; end
                    if (data_in[0]) begin
                        if (run0) m_err = 1'b1;
                        else begin m_running = 1'b1; m_finished = 1'b0; m_cycles = 0; exp_start = 1'b1; end
                    end
                end else if (rg == 1 || rg == 2) begin
                    if (run0)         m_err = 1'b1;
                    else if (rg == 1) m_a[off] = data_in[7:0];
                    else              m_b[off] = data_in[7:0];
                end else if (rg == 3) m_err = 1'b1;
            end
            if (run0 && acc_done) begin
                for (int i = 0; i < DEP; i++) m_c[i] = acc_out_C[i*8 +: 8];
                m_running = 1'b0; m_finished = 1'b1;
            end
        end
        exp_irq = m_finished;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(logic [31:0] a, logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; data_in = d;
        tick();
        req = 1'b0; we = 1'b0;
    endtask

    task automatic do_read(logic [31:0] a);
        req = 1'b1; we = 1'b0; addr = a;
        tick();
        req = 1'b0;
    endtask

    task automatic randomize_c();
        for (int i = 0; i < DEP / 4; i++) acc_out_C[i*32 +: 32] = $urandom();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
        n_cmp++; if (data_out !== 32'd0) begin n_fail++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
        n_cmp++; if ({acc_start, irq} !== 2'b00) begin n_fail++; $display("FAIL reset_start_irq: got %b expected 00", {acc_start, irq}); end
        do_read(mk(0, 1));
        n_cmp++; if (data_out !== 32'd0) begin n_fail++; $display("FAIL reset_status: got %h expected 0", data_out); end
    endtask

    task automatic test_rw_buffers();
        do_write(mk(1, 0), 32'hFFFF_FF5A);
        do_write(mk(2, 1023), 32'h0000_12C3);
        do_read(mk(1, 0));
        n_cmp++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL rw_rvalid_a: got %b expected 1", rvalid); end
        n_cmp++; if (data_out !== 32'h5A) begin n_fail++; $display("FAIL rw_read_a: got %h expected 5a", data_out); end
        do_read(mk(2, 1023));
        n_cmp++; if (data_out !== 32'hC3 || rvalid !== 1'b1) begin n_fail++; $display("FAIL rw_read_b: got %h/%b expected c3/1", data_out, rvalid); end
        tick();
        n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rw_rvalid_drop: got %b expected 0", rvalid); end
        n_cmp++; if (data_out !== 32'hC3) begin n_fail++; $display("FAIL rw_data_hold: got %h expected c3", data_out); end
        n_cmp++; if (acc_in_A[7:0] !== 8'h5A) begin n_fail++; $display("FAIL rw_flat_a: got %h expected 5a", acc_in_A[7:0]); end
        n_cmp++; if (acc_in_B[1023*8 +: 8] !== 8'hC3) begin n_fail++; $display("FAIL rw_flat_b: got %h expected c3", acc_in_B[1023*8 +: 8]); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) do_write(mk(1, i + 4), $urandom());
        req = 1'b1; we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            addr = mk(1, i + 4);
            tick();
            n_cmp++;
            if (rvalid !== 1'b1 || data_out !== exp_rdata) begin
                n_fail++; $display("FAIL b2b_read%0d: got %h/%b expected %h/1", i, data_out, rvalid, exp_rdata);
            end
        end
        req = 1'b0;
    endtask

    task automatic test_run();
        do_write(mk(0, 0), 32'd1);
        n_cmp++; if (acc_start !== 1'b1) begin n_fail++; $display("FAIL run_start: got %b expected 1", acc_start); end
        do_read(mk(0, 1));
        n_cmp++; if (data_out !== 32'd1) begin n_fail++; $display("FAIL run_busy: got %h expected 1", data_out); end
        n_cmp++; if (acc_start !== 1'b0) begin n_fail++; $display("FAIL run_start_pulse: got %b expected 0", acc_start); end
        for (int i = 0; i < 9; i++) tick();
        randomize_c();
        acc_out_C[5*8 +: 8] = 8'h77;
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
        n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL run_irq: got %b expected 1", irq); end
        do_read(mk(0, 2));
        n_cmp++; if (data_out !== 32'd11) begin n_fail++; $display("FAIL run_cycles: got %0d expected 11", data_out); end
        do_read(mk(3, 5));
        n_cmp++; if (data_out !== 32'h77) begin n_fail++; $display("FAIL run_c5: got %h expected 77", data_out); end
        for (int i = 0; i < 4; i++) begin
            do_read(mk(3, $urandom_range(0, DEP - 1)));
            n_cmp++; if (data_out !== exp_rdata) begin n_fail++; $display("FAIL run_c_rand: got %h expected %h", data_out, exp_rdata); end
        end
    endtask

    task automatic test_protect();
        do_write(mk(1, 3), 32'h33);
        do_write(mk(0, 0), 32'd1);
        do_write(mk(1, 3), 32'hFF);
        do_write(mk(0, 0), 32'd1);
        n_cmp++; if (acc_start !== 1'b0) begin n_fail++; $display("FAIL prot_no_restart: got %b expected 0", acc_start); end
        do_read(mk(0, 1));
        n_cmp++; if (data_out !== 32'b101) begin n_fail++; $display("FAIL prot_status: got %h expected 5", data_out); end
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
        n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL prot_irq: got %b expected 1", irq); end
        do_read(mk(1, 3));
        n_cmp++; if (data_out !== 32'h33) begin n_fail++; $display("FAIL prot_a3: got %h expected 33", data_out); end
        do_write(mk(3, 7), 32'h12);
        do_read(mk(3, 7));
        n_cmp++; if (data_out !== exp_rdata) begin n_fail++; $display("FAIL prot_c_ro: got %h expected %h", data_out, exp_rdata); end
    endtask

    task automatic test_restart();
        do_write(mk(0, 0), 32'd3);
        n_cmp++; if ({acc_start, irq} !== 2'b10) begin n_fail++; $display("FAIL rst_start_irq: got %b expected 10", {acc_start, irq}); end
        do_read(mk(0, 1));
        n_cmp++; if (data_out !== 32'b001) begin n_fail++; $display("FAIL restart_status: got %h expected 1", data_out); end
        do_read(mk(0, 2));
        n_cmp++; if (data_out !== exp_rdata || data_out > 32'd2) begin n_fail++; $display("FAIL restart_cycles: got %0d expected %0d", data_out, exp_rdata); end
    endtask

    task automatic test_same_cycle();
        randomize_c();
        req = 1'b1; we = 1'b1; addr = mk(0, 0); data_in = 32'd1; acc_done = 1'b1;
        tick();
        req = 1'b0; we = 1'b0; acc_done = 1'b0;
        n_cmp++; if ({acc_start, irq} !== 2'b01) begin n_fail++; $display("FAIL same_start_irq: got %b expected 01", {acc_start, irq}); end
        do_read(mk(0, 1));
        n_cmp++; if (data_out !== 32'b110) begin n_fail++; $display("FAIL same_status: got %h expected 6", data_out); end
    endtask

    task automatic test_reset_mid_run();
        do_write(mk(0, 0), 32'd3);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if ({rvalid, acc_start, irq} !== 3'b000) begin n_fail++; $display("FAIL midrst_outs: got %b expected 000", {rvalid, acc_start, irq}); end
        do_read(mk(0, 1));
        n_cmp++; if (data_out !== 32'd0) begin n_fail++; $display("FAIL midrst_status: got %h expected 0", data_out); end
        do_read(mk(0, 2));
        n_cmp++; if (data_out !== 32'd0) begin n_fail++; $display("FAIL midrst_cycles: got %h expected 0", data_out); end
        do_read(mk(1, 0));
        n_cmp++; if (data_out !== 32'd0) begin n_fail++; $display("FAIL midrst_a0: got %h expected 0", data_out); end
        randomize_c();
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
        n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL midrst_irq: got %b expected 0", irq); end
        do_read(mk(3, 5));
        n_cmp++; if (data_out !== 32'd0) begin n_fail++; $display("FAIL midrst_c5: got %h expected 0", data_out); end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int n = 0; n < 400; n++) begin
            int rg = $urandom_range(0, 3);
            int off = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEP - 1) : $urandom_range(0, 15);
            req = ($urandom_range(0, 2) != 0);
            we = $urandom_range(0, 1);
            addr = mk(rg, off);
            data_in = (rg == 0) ? 32'($urandom_range(0, 3)) : $urandom();
            acc_done = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) randomize_c();
            tick();
            n_cmp++;
            if (rvalid !== exp_rvalid || (exp_rvalid && data_out !== exp_rdata)) begin
                n_fail++; $display("FAIL rand_read%0d: got %h/%b expected %h/%b", n, data_out, rvalid, exp_rdata, exp_rvalid);
            end
            n_cmp++;
            if ({acc_start, irq} !== {exp_start, exp_irq}) begin
                n_fail++; $display("FAIL rand_ctrl%0d: got %b expected %b", n, {acc_start, irq}, {exp_start, exp_irq});
            end
        end
        req = 1'b0; acc_done = 1'b0;
        for (int i = 0; i < DEP; i++) begin
            if (acc_in_A[i*8 +: 8] !== m_a[i] || acc_in_B[i*8 +: 8] !== m_b[i]) bad++;
        end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL rand_flat_ab: got %0d differing elements expected 0", bad); end
    endtask

    task automatic test_small_params();
        s_req = 1'b1; s_we = 1'b1; s_addr = 32'h1F; s_data_in = 32'h1234_BEEF;
        @(posedge clk); #1;
        s_we = 1'b0;
        @(posedge clk); #1;
        s_req = 1'b0;
        n_cmp++; if (s_rvalid !== 1'b1 || s_data_out !== 32'hBEEF) begin n_fail++; $display("FAIL small_a15: got %h/%b expected beef/1", s_data_out, s_rvalid); end
        n_cmp++; if (s_acc_in_A[255:240] !== 16'hBEEF) begin n_fail++; $display("FAIL small_flat: got %h expected beef", s_acc_in_A[255:240]); end
        s_req = 1'b1; s_we = 1'b1; s_addr = 32'h0; s_data_in = 32'd1;
        @(posedge clk); #1;
        s_req = 1'b0; s_we = 1'b0;
        n_cmp++; if (s_acc_start !== 1'b1) begin n_fail++; $display("FAIL small_start: got %b expected 1", s_acc_start); end
        repeat (20) @(posedge clk);
        #1;
        s_req = 1'b1; s_addr = 32'h2;
        @(posedge clk); #1;
        s_req = 1'b0;
        n_cmp++; if (s_data_out !== 32'hF) begin n_fail++; $display("FAIL small_sat: got %h expected f", s_data_out); end
        s_acc_done = 1'b1;
        @(posedge clk); #1;
        s_acc_done = 1'b0;
        n_cmp++; if (s_irq !== 1'b1) begin n_fail++; $display("FAIL small_irq: got %b expected 1", s_irq); end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'd0; data_in = 32'd0; acc_done = 1'b0; acc_out_C = '0;
        s_rst = 1'b1; s_req = 1'b0; s_we = 1'b0; s_addr = 32'd0; s_data_in = 32'd0; s_acc_done = 1'b0; s_acc_out_C = '0;
        exp_rdata = 32'd0;
        test_reset();
        s_rst = 1'b0;
        test_rw_buffers();
        test_back_to_back();
        test_run();
        test_protect();
        test_restart();
        test_same_cycle();
        test_reset_mid_run();
        test_random();
        test_small_params();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
